sha256_req_sched: RTL and testbench
===================================

// Module: sha256_req_sched
// PURPOSE
//  Round-robin scheduler sharing one SHA256_node among num_req_p requesters.
//  Grants a requester and streams its 256-bit message into the node as ring_width_p words.
//  Captures the digest and returns it tagged with the requester index.
//  Sits between the requester-side ring/FIFOs and the single hash node.
// PARAMETERS
//  num_req_p      4   number of requesters (>=2)
//  ring_width_p   32  word width into SHA256_node; must divide 256
//  words_lp       256/ring_width_p  words per message (derived, localparam)
//  id_width_lp    $clog2(num_req_p)  requester tag width (derived, localparam)
// PORTS
//  clk_i        in   1                       clock
//  reset_n_i    in   1                       async active-low reset
//  en_i         in   1                       global enable; 0 freezes all handshakes
//  req_v_i      in   num_req_p               per-requester word valid
//  req_data_i   in   num_req_p*ring_width_p  per-requester word, requester k at [k*W +: W]
//  req_ready_o  out  num_req_p               per-requester word accepted (only granted bit can be 1)
//  node_v_o     out  1                       word valid to SHA256_node v_i
//  node_data_o  out  ring_width_p            word to SHA256_node data_i
//  node_ready_i in   1                       SHA256_node ready_o
//  node_v_i     in   1                       SHA256_node v_o (digest valid)
//  node_data_i  in   256                     SHA256_node data_o (digest)
//  node_yumi_o  out  1                       digest consumed, to SHA256_node yumi_i
//  dig_v_o      out  1                       tagged digest valid
//  dig_data_o   out  256                     registered digest
//  dig_id_o     out  id_width_lp             index of requester owning dig_data_o
//  dig_yumi_i   in   1                       downstream consumes digest
//  busy_o       out  1                       state != IDLE
// BEHAVIOUR
//  Reset (async, reset_n_i=0): state=IDLE, word_cnt=0, grant=0, last_grant=num_req_p-1,
//   dig_data_o=0, dig_id_o=0; all v/ready/yumi outputs 0, busy_o=0.
//  en_i=0: req_ready_o, node_v_o, node_yumi_o, dig_v_o forced 0; state, counters, regs hold.
//  States (en_i=1):
//   IDLE:   if |req_v_i, grant = first set bit searching last_grant+1 .. wrapping; -> SEND next cycle.
//           No word transfers in IDLE (1-cycle arbitration bubble).
//   SEND:   node_v_o=req_v_i[grant]; node_data_o=req_data_i[grant]; req_ready_o[grant]=node_ready_i.
//           Word handshake = req_v_i[grant] & node_ready_i; word_cnt++ on each.
//           Handshake with word_cnt==words_lp-1 -> word_cnt=0, -> WAIT.
//           Granted requester dropping v mid-message: stall in SEND, no timeout, no regrant.
//   WAIT:   node_yumi_o=node_v_i; when node_v_i: latch node_data_i->dig_data_o, grant->dig_id_o; -> RETURN.
//   RETURN: dig_v_o=1; dig_data_o/dig_id_o stable until dig_yumi_i; on dig_yumi_i: last_grant=grant, -> IDLE.
//  node_v_i outside WAIT: ignored, node_yumi_o=0. dig_yumi_i outside RETURN: ignored.
//  New requests during SEND/WAIT/RETURN wait; fairness: requester just served has lowest priority next.
//  Latency: grant+words_lp word cycles (no stalls) + node hash time + 1 capture cycle to dig_v_o.
//  Outputs in IDLE/WAIT/RETURN: node_v_o=0, req_ready_o=0, node_data_o=0.
//  Reset mid-operation: immediate return to reset state; partial message discarded, no digest emitted.
// STRUCTURE
//  sha256_pkg: digest_width_lp=256; state enum {IDLE,SEND,WAIT,RETURN}.
//  Sub-module sha256_rr_arb: combinational round-robin pick (req vector, last_grant -> grant, any_v).
//  Top holds FSM, word counter, grant/last_grant regs, digest capture regs, data mux.
// TESTING
//  T1 reset: reset_n_i=0 mid-SEND word 3 -> all outputs 0, busy_o=0 same cycle; next grant from req0.
//  T2 single req: req1 streams 8 words 0x11111111..0x88888888, node_ready_i=1 -> 8 node handshakes,
//     node digest 0xAB..AB -> dig_v_o=1, dig_id_o=1, dig_data_o=0xAB..AB until dig_yumi_i.
//  T3 fairness: req_v_i=4'b1111 continuously, 4 messages -> grant order 0,1,2,3; 5th grant=0.
//  T4 backpressure: node_ready_i toggles 1/0 in SEND -> word_cnt advances only on handshake; 16 cycles for 8 words.
//  T5 en_i=0 for 5 cycles in SEND at word 4 and in RETURN -> no handshakes, word_cnt=4 held, digest held.
//  T6 spurious: node_v_i=1 in IDLE, dig_yumi_i=1 in WAIT -> node_yumi_o=0, state unchanged.

Source files
------------

// File: rtl/sha256_pkg.sv
// Shared types for the SHA-256 request scheduler: digest width and scheduler FSM states.
package sha256_pkg;

    localparam int digest_width_lp = 256;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SEND   = 2'd1,
        WAIT   = 2'd2,
        RETURN = 2'd3
    } state_e;

endpackage

// File: rtl/sha256_rr_arb.sv
// Combinational round-robin pick: the first requesting index after i_last_grant, wrapping,
// so the most recently served requester always has the lowest priority.
module sha256_rr_arb #(
    parameter  int num_req_p   = 4,
    localparam int id_width_lp = $clog2(num_req_p)
) (
    input  logic [num_req_p-1:0]   i_req_v,
    input  logic [id_width_lp-1:0] i_last_grant,
    output logic [id_width_lp-1:0] o_grant,
    output logic                   o_any_v
);

    int w_best_d;

    // Distance 0 is the slot right after last_grant; the smallest distance with a request wins.
    always_comb begin
        o_grant  = '0;
        o_any_v  = 1'b0;
        w_best_d = num_req_p;
        for (int j = 0; j < num_req_p; j++) begin
            if (i_req_v[j] &&
                (((j + num_req_p - 1 - int'(i_last_grant)) % num_req_p) < w_best_d)) begin
                w_best_d = (j + num_req_p - 1 - int'(i_last_grant)) % num_req_p;
                o_grant  = id_width_lp'(j);
                o_any_v  = 1'b1;
            end
        end
    end

endmodule

// File: rtl/sha256_req_sched.sv
// Round-robin scheduler sharing one SHA-256 node among several requesters: streams the granted
// requester's message into the node word by word, then returns the digest tagged with its owner.
module sha256_req_sched
    import sha256_pkg::*;
#(
    parameter  int num_req_p    = 4,
    parameter  int ring_width_p = 32,
    localparam int id_width_lp  = $clog2(num_req_p)
) (
    input  logic                              clk_i,
    input  logic                              reset_n_i,
    input  logic                              en_i,
    input  logic [num_req_p-1:0]              req_v_i,
    input  logic [num_req_p*ring_width_p-1:0] req_data_i,
    output logic [num_req_p-1:0]              req_ready_o,
    output logic                              node_v_o,
    output logic [ring_width_p-1:0]           node_data_o,
    input  logic                              node_ready_i,
    input  logic                              node_v_i,
    input  logic [digest_width_lp-1:0]        node_data_i,
    output logic                              node_yumi_o,
    output logic                              dig_v_o,
    output logic [digest_width_lp-1:0]        dig_data_o,
    output logic [id_width_lp-1:0]            dig_id_o,
    input  logic                              dig_yumi_i,
    output logic                              busy_o
);

    localparam int words_lp     = digest_width_lp / ring_width_p;
    localparam int cnt_width_lp = (words_lp > 1) ? $clog2(words_lp) : 1;

    state_e                      r_state,      w_state_next;
    logic [cnt_width_lp-1:0]     r_word_cnt,   w_word_cnt_next;
    logic [id_width_lp-1:0]      r_grant,      w_grant_next;
    logic [id_width_lp-1:0]      r_last_grant, w_last_grant_next;
    logic [digest_width_lp-1:0]  r_dig_data,   w_dig_data_next;
    logic [id_width_lp-1:0]      r_dig_id,     w_dig_id_next;

    logic [id_width_lp-1:0]      w_arb_grant;
    logic                        w_any_v;
    logic [ring_width_p-1:0]     w_req_word [num_req_p];
    logic [ring_width_p-1:0]     w_sel_word;
    logic                        w_sel_v;
    logic                        w_word_hs;

    for (genvar gi = 0; gi < num_req_p; gi++) begin : g_unpack
        assign w_req_word[gi] = req_data_i[gi*ring_width_p +: ring_width_p];
    end

    assign w_sel_word = w_req_word[r_grant];
    assign w_sel_v    = req_v_i[r_grant];
    assign w_word_hs  = en_i && (r_state == SEND) && w_sel_v && node_ready_i;

    sha256_rr_arb #(
        .num_req_p    (num_req_p)
    ) u_arb (
        .i_req_v      (req_v_i),
        .i_last_grant (r_last_grant),
        .o_grant      (w_arb_grant),
        .o_any_v      (w_any_v)
    );

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            r_state      <= IDLE;
            r_word_cnt   <= '0;
            r_grant      <= '0;
            r_last_grant <= id_width_lp'(num_req_p - 1);
            r_dig_data   <= '0;
            r_dig_id     <= '0;
        end else begin
            r_state      <= w_state_next;
            r_word_cnt   <= w_word_cnt_next;
            r_grant      <= w_grant_next;
            r_last_grant <= w_last_grant_next;
            r_dig_data   <= w_dig_data_next;
            r_dig_id     <= w_dig_id_next;
        end
    end

    // With en_i low every register holds, so the whole scheduler freezes in place.
    always_comb begin
        w_state_next      = r_state;
        w_word_cnt_next   = r_word_cnt;
        w_grant_next      = r_grant;
        w_last_grant_next = r_last_grant;
        w_dig_data_next   = r_dig_data;
        w_dig_id_next     = r_dig_id;
        if (en_i) begin
            case (r_state)
                IDLE: begin
                    if (w_any_v) begin
                        w_grant_next = w_arb_grant;
                        w_state_next = SEND;
                    end
                end
                SEND: begin
                    if (w_word_hs) begin
                        if (r_word_cnt == cnt_width_lp'(words_lp - 1)) begin
                            w_word_cnt_next = '0;
                            w_state_next    = WAIT;
                        end else begin
                            w_word_cnt_next = r_word_cnt + 1'b1;
                        end
                    end
                end
                WAIT: begin
                    if (node_v_i) begin
                        w_dig_data_next = node_data_i;
                        w_dig_id_next   = r_grant;
                        w_state_next    = RETURN;
                    end
                end
                RETURN: begin
                    if (dig_yumi_i) begin
                        w_last_grant_next = r_grant;
                        w_state_next      = IDLE;
                    end
                end
                default: w_state_next = IDLE;
            endcase
        end
    end

    // Data follows the granted requester throughout SEND; only the handshake strobes honour en_i.
    always_comb begin
        req_ready_o = '0;
        node_v_o    = 1'b0;
        node_data_o = '0;
        node_yumi_o = 1'b0;
        dig_v_o     = 1'b0;
        if (r_state == SEND) begin
            node_data_o = w_sel_word;
            if (en_i) begin
                node_v_o             = w_sel_v;
                req_ready_o[r_grant] = node_ready_i;
            end
        end
        if (en_i && (r_state == WAIT)) begin
            node_yumi_o = node_v_i;
        end
        if (en_i && (r_state == RETURN)) begin
            dig_v_o = 1'b1;
        end
    end

    assign busy_o     = (r_state != IDLE);
    assign dig_data_o = r_dig_data;
    assign dig_id_o   = r_dig_id;

endmodule

// File: tb/tb_sha256_req_sched.sv
// Directed bench for sha256_req_sched: a transaction-level model checked every cycle on the
// falling edge, plus hand-computed expectations for each scenario.
module tb_sha256_req_sched;

    localparam int N     = 4;
    localparam int W     = 32;
    localparam int WORDS = 8;

    logic             clk_i = 1'b0;
    logic             reset_n_i;
    logic             en_i;
    logic [N-1:0]     req_v_i;
    logic [N*W-1:0]   req_data_i;
    logic [N-1:0]     req_ready_o;
    logic             node_v_o;
    logic [W-1:0]     node_data_o;
    logic             node_ready_i;
    logic             node_v_i;
    logic [255:0]     node_data_i;
    logic             node_yumi_o;
    logic             dig_v_o;
    logic [255:0]     dig_data_o;
    logic [1:0]       dig_id_o;
    logic             dig_yumi_i;
    logic             busy_o;

    int errors = 0;
    int checks = 0;

    // Requester sources: words loaded (written by stimulus) and words accepted (written by monitor).
    int src_load [N] = '{default: 0};
    int src_done [N] = '{default: 0};

    // Model state and monitor logs.
    int           m_owner, m_sent, m_last, m_dig_id, m_ow;
    bit           m_have, m_sending, m_waiting, m_own_v;
    logic [255:0] m_dig;
    logic [N-1:0] e_ready, hs_req;
    logic [W-1:0] e_nd;
    int           grant_log [$];
    logic [W-1:0] node_log [$];
    int           hs_total    = 0;
    int           send_cycles = 0;

    always #5 clk_i = ~clk_i;

    sha256_req_sched #(
        .num_req_p    (N),
        .ring_width_p (W)
    ) dut (
        .clk_i        (clk_i),
        .reset_n_i    (reset_n_i),
        .en_i         (en_i),
        .req_v_i      (req_v_i),
        .req_data_i   (req_data_i),
        .req_ready_o  (req_ready_o),
        .node_v_o     (node_v_o),
        .node_data_o  (node_data_o),
        .node_ready_i (node_ready_i),
        .node_v_i     (node_v_i),
        .node_data_i  (node_data_i),
        .node_yumi_o  (node_yumi_o),
        .dig_v_o      (dig_v_o),
        .dig_data_o   (dig_data_o),
        .dig_id_o     (dig_id_o),
        .dig_yumi_i   (dig_yumi_i),
        .busy_o       (busy_o)
    );

    function automatic logic [31:0] src_word(input int k, input int j);
        logic [31:0] unit = 32'h11111111;
        return (unit * 32'((j % 8) + 1)) ^ (32'(k ^ 1) << 24);
    endfunction

    function automatic bit pending();
        bit p = 1'b0;
        for (int k = 0; k < N; k++) if (src_load[k] > src_done[k]) p = 1'b1;
        return p;
    endfunction

    function automatic int rr_pick(input int last, input logic [N-1:0] v);
        int c;
        for (int i = 1; i <= N; i++) begin
            c = (last + i) % N;
            if (v[c[1:0]]) return c;
        end
        return -1;
    endfunction

    always_comb begin
        req_v_i    = '0;
        req_data_i = '0;
        for (int k = 0; k < N; k++) begin
            if (src_load[k] > src_done[k]) begin
                req_v_i[k]           = 1'b1;
                req_data_i[k*W +: W] = src_word(k, src_done[k]);
            end
        end
    end

    task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic m_reset();
        m_owner  = -1;
        m_sent   = 0;
        m_have   = 1'b0;
        m_last   = N - 1;
        m_dig    = '0;
        m_dig_id = 0;
    endtask

    // Monitor: compare every output against the model on the falling edge, then advance the model.
    initial begin : compare
        m_reset();
        forever begin
            @(negedge clk_i);
            if (!reset_n_i) m_reset();
            m_sending = (m_owner >= 0) && !m_have && (m_sent < WORDS);
            m_waiting = (m_owner >= 0) && !m_have && (m_sent == WORDS);
            m_ow      = (m_owner >= 0) ? m_owner : 0;
            m_own_v   = (m_owner >= 0) && req_v_i[m_ow[1:0]];
            e_ready   = (en_i && m_sending) ? (N'(node_ready_i) << m_ow) : '0;
            e_nd      = m_sending ? req_data_i[m_ow*W +: W] : '0;

            chk("busy",      256'(busy_o),      256'(m_owner >= 0));
            chk("node_v",    256'(node_v_o),    256'(en_i && m_sending && m_own_v));
            chk("req_ready", 256'(req_ready_o), 256'(e_ready));
            chk("node_data", 256'(node_data_o), 256'(e_nd));
            chk("node_yumi", 256'(node_yumi_o), 256'(en_i && m_waiting && node_v_i));
            chk("dig_v",     256'(dig_v_o),     256'(en_i && m_have));
            chk("dig_data",  dig_data_o,        m_dig);
            chk("dig_id",    256'(dig_id_o),    256'(m_dig_id));

            hs_req = req_v_i & req_ready_o;
            if (node_v_o && node_ready_i) begin
                node_log.push_back(node_data_o);
                hs_total++;
            end
            if (en_i && m_sending) send_cycles++;
            if (reset_n_i && dig_v_o && dig_yumi_i)
                $display("digest id=%0d data=%h", dig_id_o, dig_data_o);

            if (reset_n_i && en_i) begin
                if (m_owner < 0) begin
                    if (|req_v_i) begin
                        m_owner = rr_pick(m_last, req_v_i);
                        m_sent  = 0;
                        grant_log.push_back(m_owner);
                    end
                end else if (m_have) begin
                    if (dig_yumi_i) begin
                        m_last  = m_owner;
                        m_owner = -1;
                        m_have  = 1'b0;
                    end
                end else if (m_sent < WORDS) begin
                    if (m_own_v && node_ready_i) m_sent++;
                end else if (node_v_i) begin
                    m_have   = 1'b1;
                    m_dig    = node_data_i;
                    m_dig_id = m_owner;
                end
            end

            @(posedge clk_i);
            #1;
            for (int k = 0; k < N; k++) if (hs_req[k]) src_done[k]++;
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk_i);
        #2;
    endtask

    task automatic wait_idle(input string name, input int max);
        int n = 0;
        while ((busy_o || pending()) && n < max) begin
            tick(1);
            n++;
        end
        chk(name, 256'(busy_o || pending()), 256'(0));
    endtask

    task automatic wait_dig(input string name, input int max);
        int n = 0;
        while (!dig_v_o && n < max) begin
            tick(1);
            n++;
        end
        chk(name, 256'(dig_v_o), 256'(1));
    endtask

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

    initial begin : stimulus
        int h0, nb, gb, sc0;
        logic [255:0] d5;
        d5 = {8{32'h5A5A0F0F}};

        reset_n_i    = 1'b0;
        en_i         = 1'b1;
        node_ready_i = 1'b0;
        node_v_i     = 1'b0;
        node_data_i  = '0;
        dig_yumi_i   = 1'b0;
        tick(3);
        chk("rst_busy",      256'(busy_o),      256'(0));
        chk("rst_dig_v",     256'(dig_v_o),     256'(0));
        chk("rst_req_ready", 256'(req_ready_o), 256'(0));
        chk("rst_dig_data",  dig_data_o,        256'(0));
        chk("rst_dig_id",    256'(dig_id_o),    256'(0));
        reset_n_i = 1'b1;

        // T2: requester 1 alone, eight words, digest held until consumed.
        node_ready_i = 1'b1;
        h0 = hs_total;
        nb = node_log.size();
        src_load[1] = src_done[1] + 8;
        tick(10);
        node_data_i = {32{8'hAB}};
        node_v_i    = 1'b1;
        wait_dig("t2_dig_timeout", 10);
        node_v_i = 1'b0;
        tick(3);
        chk("t2_dig_v",    256'(dig_v_o),  256'(1));
        chk("t2_dig_id",   256'(dig_id_o), 256'(1));
        chk("t2_dig_data", dig_data_o,     {32{8'hAB}});
        chk("t2_words",    256'(hs_total - h0), 256'(8));
        chk("t2_word0",    256'(node_log.size() > nb     ? node_log[nb]     : 32'h0), 256'(32'h11111111));
        chk("t2_word7",    256'(node_log.size() > nb + 7 ? node_log[nb + 7] : 32'h0), 256'(32'h88888888));
        chk("t2_grant",    256'(grant_log[grant_log.size() - 1]), 256'(1));
        dig_yumi_i = 1'b1;
        tick(1);
        dig_yumi_i = 1'b0;
        chk("t2_idle", 256'(busy_o), 256'(0));

        // T1: reset while requester 2 is on word 3; afterwards requester 0 wins.
        h0 = hs_total;
        src_load[2] = src_done[2] + 8;
        tick(4);
        chk("t1_words_before_rst", 256'(hs_total - h0), 256'(3));
        reset_n_i = 1'b0;
        #1;
        chk("t1_rst_busy",      256'(busy_o),      256'(0));
        chk("t1_rst_node_v",    256'(node_v_o),    256'(0));
        chk("t1_rst_req_ready", 256'(req_ready_o), 256'(0));
        tick(2);
        src_load[2] = src_done[2] + 8;
        src_load[0] = src_done[0] + 8;
        reset_n_i   = 1'b1;
        tick(1);
        chk("t1_grant_after_rst", 256'(grant_log[grant_log.size() - 1]), 256'(0));
        chk("t1_req_ready",       256'(req_ready_o), 256'(4'b0001));
        chk("t1_first_word",      256'(node_data_o), 256'(32'h10111111));
        node_data_i = {8{32'hC0DE1234}};
        node_v_i    = 1'b1;
        dig_yumi_i  = 1'b1;
        wait_idle("t1_drain", 100);
        chk("t1_second_grant", 256'(grant_log[grant_log.size() - 1]), 256'(2));

        // T3: everyone requesting from reset; requester 0 has two messages queued.
        reset_n_i = 1'b0;
        tick(1);
        reset_n_i = 1'b1;
        gb = grant_log.size();
        src_load[0] = src_done[0] + 16;
        for (int k = 1; k < N; k++) src_load[k] = src_done[k] + 8;
        wait_idle("t3_drain", 300);
        chk("t3_grants", 256'(grant_log.size() - gb), 256'(5));
        for (int i = 0; i < 5; i++)
            chk($sformatf("t3_grant%0d", i),
                256'(grant_log.size() > gb + i ? grant_log[gb + i] : -1), 256'(i % 4));

        // T4: node_ready alternating during SEND doubles the word phase to 16 cycles.
        h0  = hs_total;
        sc0 = send_cycles;
        node_ready_i = 1'b1;
        src_load[3] = src_done[3] + 8;
        for (int i = 0; i < 20; i++) begin
            tick(1);
            node_ready_i = ~node_ready_i;
        end
        node_ready_i = 1'b1;
        wait_idle("t4_drain", 50);
        chk("t4_send_cycles", 256'(send_cycles - sc0), 256'(16));
        chk("t4_words",       256'(hs_total - h0),     256'(8));
        chk("t4_grant",       256'(grant_log[grant_log.size() - 1]), 256'(3));

        // T5: en_i low for five cycles at word 4 and again while the digest is offered.
        node_v_i   = 1'b0;
        dig_yumi_i = 1'b0;
        h0 = hs_total;
        src_load[0] = src_done[0] + 8;
        tick(5);
        chk("t5_words_before_freeze", 256'(hs_total - h0), 256'(4));
        en_i = 1'b0;
        tick(5);
        chk("t5_words_frozen",     256'(hs_total - h0), 256'(4));
        chk("t5_frozen_node_v",    256'(node_v_o),      256'(0));
        chk("t5_frozen_req_ready", 256'(req_ready_o),   256'(0));
        en_i = 1'b1;
        tick(5);
        chk("t5_words_total", 256'(hs_total - h0), 256'(8));
        node_data_i = d5;
        node_v_i    = 1'b1;
        wait_dig("t5_dig_timeout", 10);
        node_v_i = 1'b0;
        en_i     = 1'b0;
        tick(5);
        chk("t5_frozen_dig_v",    256'(dig_v_o),  256'(0));
        chk("t5_frozen_busy",     256'(busy_o),   256'(1));
        chk("t5_frozen_dig_data", dig_data_o,     d5);
        chk("t5_frozen_dig_id",   256'(dig_id_o), 256'(0));
        en_i = 1'b1;
        #1;
        chk("t5_dig_v_resumed", 256'(dig_v_o), 256'(1));
        tick(1);
        dig_yumi_i = 1'b1;
        tick(1);
        dig_yumi_i = 1'b0;
        chk("t5_idle", 256'(busy_o), 256'(0));

        // T6: node_v_i in IDLE and dig_yumi_i in WAIT are both ignored.
        node_v_i = 1'b1;
        tick(2);
        chk("t6_idle_yumi", 256'(node_yumi_o), 256'(0));
        chk("t6_idle_busy", 256'(busy_o),      256'(0));
        node_v_i   = 1'b0;
        dig_yumi_i = 1'b1;
        src_load[1] = src_done[1] + 8;
        tick(12);
        chk("t6_wait_busy",  256'(busy_o),      256'(1));
        chk("t6_wait_dig_v", 256'(dig_v_o),     256'(0));
        chk("t6_wait_yumi",  256'(node_yumi_o), 256'(0));
        node_data_i = {8{32'h600D600D}};
        node_v_i    = 1'b1;
        #1;
        chk("t6_still_wait", 256'(node_yumi_o), 256'(1));
        wait_idle("t6_drain", 20);
        node_v_i   = 1'b0;
        dig_yumi_i = 1'b0;
        tick(2);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
